// File: rtl/spi3_pkg.sv
// Shared definitions for the three-wire SPI read/write paths: FSM state
// encodings, default field widths and the R/W command bit.
package spi3_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  // Leading command bit that marks a register read.
  localparam logic RW_READ = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SETUP = 3'd1;
  localparam state_t S_CMD   = 3'd2;
  localparam state_t S_DATA  = 3'd3;
  localparam state_t S_HOLD  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Width of a bit counter that must index the longer of the two fields.
  function automatic int bit_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/spi3_clk_gen.sv
// Half-period divider for the three-wire serial clock. While disabled the
// serial clock parks high and the counter is cleared; while enabled the
// level toggles every CLK_DIV cycles. The rise/fall strobes are high on the
// cycle whose closing CLK edge makes the level go 0->1 / 1->0.
module spi3_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic enable,
  output logic spc,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic [7:0] half_cnt_reg;
  logic       spc_reg;
  logic       wrap;

  assign wrap = enable && (half_cnt_reg == HALF_LAST);
  assign rise = wrap && !spc_reg;
  assign fall = wrap && spc_reg;
  assign spc  = spc_reg;

  // Count CLK cycles inside the current half period and flip the level at the end.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      half_cnt_reg <= '0;
      spc_reg      <= 1'b1;
    end else if (!enable) begin
      half_cnt_reg <= '0;
      spc_reg      <= 1'b1;
    end else if (wrap) begin
      half_cnt_reg <= '0;
      spc_reg      <= ~spc_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + 8'd1;
    end
  end

endmodule

// File: rtl/spi3_read.sv
// Three-wire SPI read master. Shifts out {R/W=1, regaddr} MSB first on the
// shared SDAT line, releases it, then clocks DATA_W bits back in MSB first.
// The divider runs from SETUP through HOLD; its first high half period is the
// SETUP time, and during HOLD its low half is masked so SPC stays high.
module spi3_read
  import spi3_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              GO,
  input  logic [ADDR_W-1:0] regaddr,
  output logic              SPC,
  output logic              SCEN,
  inout  wire               SDAT,
  output logic [DATA_W-1:0] rdata,
  output logic              DVALID,
  output logic              ORDY
);

  localparam int CMD_W = ADDR_W + 1;
  localparam int CNT_W = bit_cnt_w(CMD_W, DATA_W);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t            state_reg, state_next;
  logic [CMD_W-1:0]  cmd_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic              ready, go_accept, div_en;
  logic              spc_div, spc_rise, spc_fall;

  assign ready     = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign go_accept = ready && GO;
  assign div_en    = !ready;

  spi3_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .CLK    (CLK),
    .reset  (reset),
    .enable (div_en),
    .spc    (spc_div),
    .rise   (spc_rise),
    .fall   (spc_fall)
  );

  // Next-state decode; phases advance on divider strobes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: state_next = GO ? S_SETUP : S_IDLE;
      S_SETUP:        if (spc_fall) state_next = S_CMD;
      S_CMD:          if (spc_fall && (bit_cnt_reg == CMD_LAST)) state_next = S_DATA;
      S_DATA:         if (spc_fall && (bit_cnt_reg == DATA_LAST)) state_next = S_HOLD;
      S_HOLD:         if (spc_rise) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Bit counter: one count per completed SPC period, cleared on every state change.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      bit_cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      bit_cnt_reg <= '0;
    end else if (spc_fall && ((state_reg == S_CMD) || (state_reg == S_DATA))) begin
      bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
    end
  end

  // Command shifter: load on accept, shift left at the end of each high phase.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cmd_reg <= '0;
    end else if (go_accept) begin
      cmd_reg <= {RW_READ, regaddr};
    end else if ((state_reg == S_CMD) && spc_fall) begin
      cmd_reg <= {cmd_reg[CMD_W-2:0], 1'b0};
    end
  end

  // Data shifter: sample SDAT on the CLK edge that raises SPC, MSB arrives first.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (go_accept) begin
      data_reg <= '0;
    end else if ((state_reg == S_DATA) && spc_rise) begin
      data_reg <= {data_reg[DATA_W-2:0], SDAT};
    end
  end

  // Result register: updated only when HOLD completes, so it lines up with DVALID.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if ((state_reg == S_HOLD) && spc_rise) begin
      rdata_reg <= data_reg;
    end
  end

  assign SPC    = spc_div | (state_reg == S_HOLD);
  assign SCEN   = ready;
  assign ORDY   = ready;
  assign DVALID = (state_reg == S_DONE);
  assign rdata  = rdata_reg;
  assign SDAT   = (state_reg == S_CMD) ? cmd_reg[CMD_W-1] : 1'bz;

endmodule

// File: tb/tb_spi3_read.sv
// Directed bench for spi3_read: lane 0 runs CLK_DIV=4, lane 1 runs CLK_DIV=2.
// Each lane has a behavioural slave on a pulled-up SDAT line, which captures
// the command bits on SPC rises and drives read data after SPC falls.
module tb_spi3_read;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Free-running cycle index, advanced on every active edge.
  always @(posedge clk) cyc++;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam int CDV = (gi == 0) ? 4 : 2;

      logic       go = 1'b0;
      logic [6:0] regaddr = '0;
      logic       spc, scen, dvalid, ordy;
      logic [7:0] rdata;
      wire        sdat;

      logic       s_oe = 1'b0;
      logic       s_bit = 1'b0;
      logic [7:0] s_data = '0;
      logic [7:0] cmd_cap = '0;
      logic [7:0] last_cmd = '0;
      int rises = 0, dv_count = 0, accepts = 0, zviol = 0;
      int present_cyc = 0, last_lat = 0, scen_lat = 0;
      int dv_cyc = -1000, fall_gap = 0, rise_cyc = 0, spc_period = 0;
      logic prev_scen = 1'b1, prev_spc = 1'b1;

      pullup (sdat);
      assign sdat = s_oe ? s_bit : 1'bz;

      spi3_read #(.CLK_DIV(CDV)) dut (
        .CLK     (clk),
        .reset   (rst),
        .GO      (go),
        .regaddr (regaddr),
        .SPC     (spc),
        .SCEN    (scen),
        .SDAT    (sdat),
        .rdata   (rdata),
        .DVALID  (dvalid),
        .ORDY    (ordy)
      );

      // Slave: count SPC rises, capture command bits, drive data after SPC falls.
      always @(posedge spc or negedge spc or posedge scen) begin
        logic [2:0] bi;
        if (scen !== 1'b0) begin
          rises = 0;
          s_oe  = 1'b0;
        end else if (spc) begin
          rises++;
          if (rises <= 8) cmd_cap = {cmd_cap[6:0], sdat};
          if (rises == 8) last_cmd = cmd_cap;
          if (rises == 16) begin
            #2;
            s_oe = 1'b0;
          end
        end else if (rises >= 8 && rises < 16) begin
          bi    = 3'(15 - rises);
          s_bit = s_data[bi];
          s_oe  = 1'b1;
        end
      end

      // Monitor: latencies, SPC period, acceptances and bus-release violations.
      always @(negedge clk) begin
        if (dvalid) begin
          dv_count++;
          last_lat = cyc - present_cyc;
          dv_cyc   = cyc;
        end
        if (prev_scen && !scen) begin
          scen_lat = cyc - present_cyc;
          fall_gap = cyc - dv_cyc;
        end
        prev_scen = scen;
        if (spc && !prev_spc) begin
          spc_period = cyc - rise_cyc;
          rise_cyc   = cyc;
        end
        prev_spc = spc;
        if ((scen || rises >= 16) && sdat !== 1'b1) zviol++;
        if (go && ordy && !rst) begin
          present_cyc = cyc;
          accepts++;
        end
      end
    end
  endgenerate

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int lane_dv(input int l);
    return (l == 0) ? g_lane[0].dv_count : g_lane[1].dv_count;
  endfunction

  function automatic int lane_rises(input int l);
    return (l == 0) ? g_lane[0].rises : g_lane[1].rises;
  endfunction

  task automatic set_go(input int l, input logic v);
    if (l == 0) g_lane[0].go = v;
    else        g_lane[1].go = v;
  endtask

  task automatic pulse_go(input int l, input logic [6:0] a);
    @(posedge clk);
    #1;
    if (l == 0) g_lane[0].regaddr = a;
    else        g_lane[1].regaddr = a;
    set_go(l, 1'b1);
    @(posedge clk);
    #1;
    set_go(l, 1'b0);
  endtask

  task automatic wait_dv(input int l, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (lane_dv(l) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, lane_dv(l), target);
  endtask

  task automatic wait_rises(input int l, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (lane_rises(l) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, (lane_rises(l) >= target) ? 1 : 0, 1);
  endtask

  task automatic report(input int l);
    if (l == 0)
      $display("read lane0 cmd=0x%02h rdata=0x%02h latency=%0d", g_lane[0].last_cmd, g_lane[0].rdata, g_lane[0].last_lat);
    else
      $display("read lane1 cmd=0x%02h rdata=0x%02h latency=%0d", g_lane[1].last_cmd, g_lane[1].rdata, g_lane[1].last_lat);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_spc",    int'(g_lane[0].spc), 1);
    check_value("rst_scen",   int'(g_lane[0].scen), 1);
    check_value("rst_sdat",   int'(g_lane[0].sdat), 1);
    check_value("rst_rdata",  int'(g_lane[0].rdata), 0);
    check_value("rst_dvalid", int'(g_lane[0].dvalid), 0);
    check_value("rst_ordy",   int'(g_lane[0].ordy), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single read of 0x32, slave returns 0xA5.
    g_lane[0].s_data = 8'hA5;
    pulse_go(0, 7'h32);
    wait_dv(0, 1, 300, "t1_dvalid");
    check_value("t1_rdata",   int'(g_lane[0].rdata), 8'hA5);
    check_value("t1_latency", g_lane[0].last_lat, 137);
    check_value("t1_scen_lat", g_lane[0].scen_lat, 1);
    check_value("t1_cmd_bits", int'(g_lane[0].last_cmd), 8'hB2);
    report(0);
    @(negedge clk);
    check_value("t1_ordy", int'(g_lane[0].ordy), 1);

    // Back-to-back: GO held through DONE.
    g_lane[0].s_data = 8'h3C;
    @(posedge clk);
    #1;
    g_lane[0].regaddr = 7'h15;
    set_go(0, 1'b1);
    wait_dv(0, 2, 300, "b2b_dvalid1");
    check_value("b2b_rdata1", int'(g_lane[0].rdata), 8'h3C);
    report(0);
    g_lane[0].s_data = 8'hC3;
    @(posedge clk);
    #1 set_go(0, 1'b0);
    wait_dv(0, 3, 300, "b2b_dvalid2");
    check_value("b2b_rdata2",  int'(g_lane[0].rdata), 8'hC3);
    check_value("b2b_scen_gap", g_lane[0].fall_gap, 1);
    check_value("b2b_latency", g_lane[0].last_lat, 137);
    check_value("b2b_accepts", g_lane[0].accepts, 3);
    report(0);

    // GO re-pulsed mid-command is ignored.
    g_lane[0].s_data = 8'h5A;
    pulse_go(0, 7'h01);
    wait_rises(0, 3, 200, "cmdgo_reach_cmd");
    pulse_go(0, 7'h7F);
    wait_dv(0, 4, 300, "cmdgo_dvalid");
    repeat (200) @(negedge clk);
    check_value("cmdgo_dv_count", g_lane[0].dv_count, 4);
    check_value("cmdgo_accepts",  g_lane[0].accepts, 4);
    check_value("cmdgo_rdata",    int'(g_lane[0].rdata), 8'h5A);
    check_value("cmdgo_cmd_bits", int'(g_lane[0].last_cmd), 8'h81);
    report(0);

    // Reset during the fourth data bit.
    g_lane[0].s_data = 8'h99;
    pulse_go(0, 7'h55);
    wait_rises(0, 12, 300, "abort_reach_data");
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_value("abort_spc",    int'(g_lane[0].spc), 1);
    check_value("abort_scen",   int'(g_lane[0].scen), 1);
    check_value("abort_sdat",   int'(g_lane[0].sdat), 1);
    check_value("abort_ordy",   int'(g_lane[0].ordy), 1);
    check_value("abort_rdata",  int'(g_lane[0].rdata), 0);
    check_value("abort_dvalid", int'(g_lane[0].dvalid), 0);
    repeat (3) @(negedge clk);
    check_value("abort_dv_count", g_lane[0].dv_count, 4);
    @(posedge clk);
    #1 rst = 1'b0;
    g_lane[0].s_data = 8'h6E;
    pulse_go(0, 7'h40);
    wait_dv(0, 5, 300, "post_abort_dvalid");
    check_value("post_abort_rdata",   int'(g_lane[0].rdata), 8'h6E);
    check_value("post_abort_latency", g_lane[0].last_lat, 137);
    check_value("post_abort_cmd",     int'(g_lane[0].last_cmd), 8'hC0);
    report(0);
    repeat (4) @(negedge clk);
    check_value("lane0_bus_release", g_lane[0].zviol, 0);

    // CLK_DIV=2 lane.
    g_lane[1].s_data = 8'hFF;
    pulse_go(1, 7'h0A);
    wait_dv(1, 1, 200, "div2_dvalid1");
    check_value("div2_rdata1",   int'(g_lane[1].rdata), 8'hFF);
    check_value("div2_latency1", g_lane[1].last_lat, 69);
    check_value("div2_period",   g_lane[1].spc_period, 4);
    check_value("div2_scen_lat", g_lane[1].scen_lat, 1);
    check_value("div2_cmd_bits", int'(g_lane[1].last_cmd), 8'h8A);
    report(1);
    g_lane[1].s_data = 8'h00;
    pulse_go(1, 7'h0B);
    wait_dv(1, 2, 200, "div2_dvalid2");
    check_value("div2_rdata2",   int'(g_lane[1].rdata), 8'h00);
    check_value("div2_latency2", g_lane[1].last_lat, 69);
    report(1);
    repeat (4) @(negedge clk);
    check_value("lane1_bus_release", g_lane[1].zviol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
